// File: rtl/parking_pkg.sv
// Shared constants and BCD helpers for the parking-lot occupancy counter.
// The BCD sign logic in the top module is built only when PARKING_BCD_EN is defined.
package parking_pkg;

    localparam int DEFAULT_CAPACITY = 20;
    localparam int DEFAULT_CNT_W    = 7;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_tens(input int value);
        return BCD_W'(value / 10);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_units(input int value);
        return BCD_W'(value % 10);
    endfunction

    // {tens, units} of the default capacity, i.e. what the sign shows after reset
    localparam logic [2*BCD_W-1:0] DEFAULT_CAP_BCD =
        {bcd_tens(DEFAULT_CAPACITY), bcd_units(DEFAULT_CAPACITY)};

endpackage

// File: rtl/parking_edge_det.sv
// Rising-edge detector: a level held high for many cycles yields a single event.
// The previous value resets to 0, so a level already high after reset is an event.
module parking_edge_det
    import parking_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic evt
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign evt = in & ~in_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Saturating parked-car counter with full/empty flags, sticky error flags and free-space output.
// Define PARKING_BCD_EN to build the BCD tens/units free-space digits; otherwise they read 0.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CNT_W    = DEFAULT_CNT_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic [BCD_W-1:0] free_tens,
    output logic [BCD_W-1:0] free_units
);

    localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

    logic             inc_evt;
    logic             dec_evt;
    logic             accept_inc;
    logic             accept_dec;
    logic             reject_inc;
    logic             reject_dec;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] free_r;
    logic             ovf_r;
    logic             unf_r;

    parking_edge_det u_inc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (inc),
        .evt   (inc_evt)
    );

    parking_edge_det u_dec_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (dec),
        .evt   (dec_evt)
    );

    // Simultaneous entry and exit cancel out and are not treated as an error
    always_comb begin
        accept_inc = 1'b0;
        accept_dec = 1'b0;
        reject_inc = 1'b0;
        reject_dec = 1'b0;
        if (inc_evt && !dec_evt) begin
            if (count_r == CAP_VAL) begin
                reject_inc = 1'b1;
            end else begin
                accept_inc = 1'b1;
            end
        end else if (dec_evt && !inc_evt) begin
            if (count_r == '0) begin
                reject_dec = 1'b1;
            end else begin
                accept_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            free_r  <= CAP_VAL;
        end else if (accept_inc) begin
            count_r <= count_r + CNT_W'(1);
            free_r  <= free_r - CNT_W'(1);
        end else if (accept_dec) begin
            count_r <= count_r - CNT_W'(1);
            free_r  <= free_r + CNT_W'(1);
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (reject_inc) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end
            if (reject_dec) begin
                unf_r <= 1'b1;
            end else if (clr_err) begin
                unf_r <= 1'b0;
            end
        end
    end

    assign count = count_r;
    assign free  = free_r;
    assign full  = (count_r == CAP_VAL);
    assign empty = (count_r == '0);
    assign ovf   = ovf_r;
    assign unf   = unf_r;

`ifdef PARKING_BCD_EN
    logic [BCD_W-1:0] tens_r;
    logic [BCD_W-1:0] units_r;

    // Digits track free directly: an accepted entry lowers free, an accepted exit raises it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_r  <= bcd_tens(CAPACITY);
            units_r <= bcd_units(CAPACITY);
        end else if (accept_inc) begin
            if (units_r == '0) begin
                units_r <= BCD_MAX;
                tens_r  <= tens_r - BCD_W'(1);
            end else begin
                units_r <= units_r - BCD_W'(1);
            end
        end else if (accept_dec) begin
            if (units_r == BCD_MAX) begin
                units_r <= '0;
                tens_r  <= tens_r + BCD_W'(1);
            end else begin
                units_r <= units_r + BCD_W'(1);
            end
        end
    end

    assign free_tens  = tens_r;
    assign free_units = units_r;
`else
    assign free_tens  = '0;
    assign free_units = '0;
`endif

endmodule
